// File: rtl/qpmm_result_writer_if.sv
// Handshake and BRAM port-A bundle between the issuer, the QPMM result writer
// and the result memory.
interface qpmm_result_writer_if #(
  parameter int DATA_W = 272,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;
  logic [DATA_W-1:0] z_in;
  logic              wr_grant;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              flush_req;
  logic              flush_done;
  logic              overflow;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output issue_valid, issue_addr, z_in, wr_grant, flush_req,
    input  issue_ready, wea, addra, dina, flush_done, overflow, wr_count
  );

  modport slave (
    input  issue_valid, issue_addr, z_in, wr_grant, flush_req,
    output issue_ready, wea, addra, dina, flush_done, overflow, wr_count
  );
endinterface

// File: rtl/qpmm_result_writer.sv
// Write-back stage of the QPMM datapath: tracks issued operands through the
// fixed core latency, buffers Z results and writes them to BRAM port A.
module qpmm_result_writer #(
  parameter int DATA_W = 272,
  parameter int ADDR_W = 8,
  parameter int LAT    = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  qpmm_result_writer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [OCC_W:0]   CREDITS  = (OCC_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2,
    ST_IDLE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LAT-1:0]    dl_valid_q, dl_valid_d;
  logic [ADDR_W-1:0] dl_addr_q [LAT];
  logic [ADDR_W-1:0] dl_addr_d [LAT];
  logic [DATA_W-1:0] fifo_data_mem [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic [OCC_W-1:0]  inflight_q, inflight_d;
  logic              issue_ready_q, issue_ready_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              flush_done_q, flush_done_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              issue_fire_s;
  logic              cap_valid_s;
  logic [ADDR_W-1:0] cap_addr_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              drained_s;

  assign cap_valid_s = dl_valid_q[LAT-1];
  assign cap_addr_s  = dl_addr_q[LAT-1];

  // Next-state logic for the delay line, credits, FIFO, write stage and FSM.
  always_comb begin
    issue_fire_s = bus.issue_valid & issue_ready_q;
    pop_s        = (count_q != '0) & bus.wr_grant;
    push_ok_s    = cap_valid_s & ((count_q != FULL_CNT) | pop_s);

    dl_valid_d    = dl_valid_q;
    dl_addr_d     = dl_addr_q;
    dl_valid_d[0] = issue_fire_s;
    dl_addr_d[0]  = bus.issue_addr;
    for (int i = 1; i < LAT; i++) begin
      dl_valid_d[i] = dl_valid_q[i-1];
      dl_addr_d[i]  = dl_addr_q[i-1];
    end

    // A capture with nothing in flight only happens on a forced push; keep the count sane.
    if (issue_fire_s && !cap_valid_s) begin
      inflight_d = inflight_q + OCC_W'(1);
    end else if (!issue_fire_s && cap_valid_s && (inflight_q != '0)) begin
      inflight_d = inflight_q - OCC_W'(1);
    end else begin
      inflight_d = inflight_q;
    end

    if (push_ok_s && !pop_s) begin
      count_d = count_q + OCC_W'(1);
    end else if (!push_ok_s && pop_s) begin
      count_d = count_q - OCC_W'(1);
    end else begin
      count_d = count_q;
    end
    wr_ptr_d   = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    overflow_d = overflow_q | (cap_valid_s & ~push_ok_s);

    wea_d = pop_s;
    if (pop_s) begin
      addra_d    = fifo_addr_mem[rd_ptr_q];
      dina_d     = fifo_data_mem[rd_ptr_q];
      wr_count_d = wr_count_q + CNT_W'(1);
    end else begin
      addra_d    = addra_q;
      dina_d     = dina_q;
      wr_count_d = wr_count_q;
    end

    // Empty FIFO means no pop this cycle, so nothing more can reach the output register.
    drained_s = (inflight_q == '0) && (count_q == '0) && !cap_valid_s;
    case (state_q)
      ST_RUN:   state_d = bus.flush_req ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = drained_s ? ST_DONE : ST_FLUSH;
      ST_DONE:  state_d = ST_IDLE;
      ST_IDLE:  state_d = bus.flush_req ? ST_IDLE : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    flush_done_d  = (state_q == ST_FLUSH) && drained_s;
    issue_ready_d = (state_d == ST_RUN) &&
                    (({1'b0, inflight_d} + {1'b0, count_d}) < CREDITS);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      dl_valid_q    <= '0;
      for (int i = 0; i < LAT; i++) begin
        dl_addr_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= '0;
      issue_ready_q <= 1'b1;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
      flush_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      dl_valid_q    <= dl_valid_d;
      dl_addr_q     <= dl_addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      issue_ready_q <= issue_ready_d;
      wea_q         <= wea_d;
      addra_q       <= addra_d;
      dina_q        <= dina_d;
      flush_done_q  <= flush_done_d;
      overflow_q    <= overflow_d;
      wr_count_q    <= wr_count_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers and count only.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_data_mem[wr_ptr_q] <= bus.z_in;
      fifo_addr_mem[wr_ptr_q] <= cap_addr_s;
    end
  end

  assign bus.issue_ready = issue_ready_q;
  assign bus.wea         = wea_q;
  assign bus.addra       = addra_q;
  assign bus.dina        = dina_q;
  assign bus.flush_done  = flush_done_q;
  assign bus.overflow    = overflow_q;
  assign bus.wr_count    = wr_count_q;
endmodule

// File: tb/tb_qpmm_result_writer.sv
// Self-checking bench for qpmm_result_writer: directed table, corner-case
// sequences and a randomized phase checked against an in-order write model.
module tb_qpmm_result_writer;
  localparam int DATA_W = 272;
  localparam int ADDR_W = 8;
  localparam int LAT    = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] z;
    logic [ADDR_W-1:0] exp_addra;
    logic [DATA_W-1:0] exp_dina;
    int                exp_lat;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  int                cyc = 0;
  int                n_checks = 0;
  int                n_fail = 0;
  logic [31:0]       seed = 32'h0;
  int                ov_cyc = -1;
  logic [DATA_W-1:0] ov_val = '0;
  int                wea_seen = 0;
  int                last_wea_cyc = 0;
  logic [CNT_W-1:0]  model_cnt = '0;
  wr_t               exp_q[$];

  qpmm_result_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  qpmm_result_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LAT(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Z value presented by the (modelled) QPMM core in cycle k.
  function automatic logic [DATA_W-1:0] z_at(input int k);
    logic [287:0] w;
    logic [31:0]  h;
    if (k == ov_cyc) return ov_val;
    h = (32'(k) * 32'h9E3779B1) ^ seed;
    for (int i = 0; i < 9; i++) w[i*32 +: 32] = h ^ (32'(i) * 32'h01000193);
    return w[DATA_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.wr_grant    = 1'b0;
    bus.flush_req   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.issue_valid = 1'b0;
    bus.wr_grant    = 1'b1;
    repeat (LAT + DEPTH + 6) step();
  endtask

  initial begin
    bus.z_in = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.z_in = z_at(cyc);
    end
  end

  // Scoreboard: every accepted issue must come out once, in order, with Z from issue+LAT.
  always @(negedge clk) begin
    if (bus.wea === 1'b1) begin
      wea_seen++;
      last_wea_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("wea_unexpected", 64'(1), 64'(0));
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        model_cnt = model_cnt + CNT_W'(1);
        chk("sb_addra", 64'(bus.addra), 64'(w.addr));
        chkw("sb_dina", bus.dina, w.data);
        chk("sb_wr_count", 64'(bus.wr_count), 64'(model_cnt));
      end
    end
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
    end else if (bus.issue_valid && bus.issue_ready) begin
      exp_q.push_back({bus.issue_addr, z_at(cyc + LAT)});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   t0, n0, got, fd_cnt, fd_cyc, consec;
    logic prev_wea;

    vecs[0] = '{8'h05, 272'hABC, 8'h05, 272'hABC, LAT + 2, 16'd1};
    vecs[1] = '{8'h00, 272'h0, 8'h00, 272'h0, LAT + 2, 16'd2};
    vecs[2] = '{8'hFF, {DATA_W{1'b1}}, 8'hFF, {DATA_W{1'b1}}, LAT + 2, 16'd3};
    vecs[3] = '{8'h05, {1'b1, 271'd0}, 8'h05, {1'b1, 271'd0}, LAT + 2, 16'd4};

    seed = $urandom;
    do_reset();
    @(negedge clk);
    chk("rst_wea", 64'(bus.wea), 64'(0));
    chk("rst_addra", 64'(bus.addra), 64'(0));
    chkw("rst_dina", bus.dina, '0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    chk("rst_wr_count", 64'(bus.wr_count), 64'(0));
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'(1));

    // Table: single issue, minimum latency, exact data/address/count.
    bus.wr_grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ov_cyc = cyc + LAT;
      ov_val = vecs[i].z;
      bus.issue_addr  = vecs[i].addr;
      bus.issue_valid = 1'b1;
      t0 = cyc;
      step();
      bus.issue_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 40 && got == 0; k++) begin
        @(negedge clk);
        if (bus.wea === 1'b1) begin
          got = 1;
          chk("vec_latency", 64'(cyc - t0), 64'(vecs[i].exp_lat));
          chk("vec_addra", 64'(bus.addra), 64'(vecs[i].exp_addra));
          chkw("vec_dina", bus.dina, vecs[i].exp_dina);
          chk("vec_wr_count", 64'(bus.wr_count), 64'(vecs[i].exp_cnt));
        end
      end
      if (got == 0) chk("vec_wea_timeout", 64'(0), 64'(1));
    end
    ov_cyc = -1;

    // Backpressure: 8 back-to-back issues with no grant, then a burst of 8 writes.
    step();
    bus.wr_grant = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'(i);
      step();
    end
    bus.issue_valid = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_8", 64'(bus.issue_ready), 64'(0));
    repeat (LAT + 4) step();
    @(negedge clk);
    chk("bp_ready_full", 64'(bus.issue_ready), 64'(0));
    step();
    bus.wr_grant = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp_burst_wea", 64'(bus.wea), 64'(1));
    end
    @(negedge clk);
    chk("bp_burst_end", 64'(bus.wea), 64'(0));
    chk("bp_ready_back", 64'(bus.issue_ready), 64'(1));
    chk("bp_overflow", 64'(bus.overflow), 64'(0));

    // Issuer ignoring issue_ready: only 8 captured; forced push while full -> sticky overflow.
    step();
    bus.wr_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'(i + 64);
      step();
    end
    bus.issue_valid = 1'b0;
    repeat (LAT + 4) step();
    @(negedge clk);
    chk("ov_before_force", 64'(bus.overflow), 64'(0));
    step();
    force dut.cap_valid_s = 1'b1;
    step();
    release dut.cap_valid_s;
    @(negedge clk);
    chk("ov_set", 64'(bus.overflow), 64'(1));
    n0 = wea_seen;
    step();
    bus.wr_grant = 1'b1;
    repeat (14) step();
    @(negedge clk);
    chk("ov_sticky", 64'(bus.overflow), 64'(1));
    chk("ov_writes", 64'(wea_seen - n0), 64'(8));
    chk("ov_sb_empty", 64'(exp_q.size()), 64'(0));
    step();
    do_reset();
    @(negedge clk);
    chk("ov_cleared_by_rst", 64'(bus.overflow), 64'(0));

    // Flush: 3 issues then flush_req; done pulse one cycle after the last write.
    step();
    bus.wr_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'(i + 32);
      step();
    end
    bus.issue_valid = 1'b0;
    bus.flush_req   = 1'b1;
    n0 = wea_seen;
    step();
    @(negedge clk);
    chk("fl_ready_low", 64'(bus.issue_ready), 64'(0));
    fd_cnt = 0;
    fd_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.flush_done === 1'b1) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
    chk("fl_writes", 64'(wea_seen - n0), 64'(3));
    chk("fl_done_pulses", 64'(fd_cnt), 64'(1));
    chk("fl_done_timing", 64'(fd_cyc), 64'(last_wea_cyc + 1));
    chk("fl_idle_ready_low", 64'(bus.issue_ready), 64'(0));
    step();
    bus.flush_req = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("fl_back_to_run", 64'(bus.issue_ready), 64'(1));

    // Reset with 2 buffered and 4 in flight: none of them may be written.
    step();
    bus.wr_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'(i + 48);
      step();
    end
    bus.issue_valid = 1'b0;
    repeat (LAT + 2) step();
    for (int i = 0; i < 4; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'(i + 50);
      step();
    end
    bus.issue_valid = 1'b0;
    step();
    n0 = wea_seen;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rr_ready", 64'(bus.issue_ready), 64'(1));
    chk("rr_wr_count", 64'(bus.wr_count), 64'(0));
    step();
    bus.wr_grant = 1'b1;
    repeat (LAT + 8) step();
    @(negedge clk);
    chk("rr_no_writes", 64'(wea_seen - n0), 64'(0));

    // Alternating grant with continuous issue attempts.
    step();
    n0 = wea_seen;
    consec = 0;
    prev_wea = 1'b0;
    for (int k = 0; k < 80; k++) begin
      bus.issue_valid = 1'b1;
      bus.issue_addr  = ADDR_W'($urandom);
      bus.wr_grant    = k[0];
      @(negedge clk);
      if (bus.wea === 1'b1 && prev_wea === 1'b1) consec++;
      prev_wea = bus.wea;
      step();
    end
    chk("tg_no_back_to_back", 64'(consec), 64'(0));
    chk("tg_some_writes", 64'(wea_seen - n0 > 20), 64'(1));
    drain();
    @(negedge clk);
    chk("tg_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("tg_overflow", 64'(bus.overflow), 64'(0));

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 600; k++) begin
      bus.issue_valid = ($urandom % 4) != 0;
      bus.issue_addr  = ADDR_W'($urandom);
      bus.wr_grant    = ($urandom % 3) != 0;
      step();
    end
    drain();
    @(negedge clk);
    chk("rnd_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("rnd_overflow", 64'(bus.overflow), 64'(0));
    chk("rnd_ready", 64'(bus.issue_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
